// File: rtl/ofdm_map_pkg.sv
// Shared constants and Gray-level helpers for the OFDM constellation mapper.
package ofdm_map_pkg;

  localparam logic MOD_QPSK  = 1'b0;
  localparam logic MOD_QAM16 = 1'b1;

  localparam int unsigned BITS_QPSK  = 2;
  localparam int unsigned BITS_QAM16 = 4;

  typedef enum logic [1:0] {
    LVL_M3,
    LVL_M1,
    LVL_P1,
    LVL_P3
  } gray_lvl_e;

  // First-received bit of the pair is the MSB of the Gray code.
  function automatic gray_lvl_e gray_to_lvl(input logic b_first, input logic b_second);
    gray_lvl_e lvl;
    unique case ({b_first, b_second})
      2'b00:   lvl = LVL_M3;
      2'b01:   lvl = LVL_M1;
      2'b11:   lvl = LVL_P1;
      default: lvl = LVL_P3;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/qam_lut.sv
// Combinational map from (mode, collected bits) to a signed I/Q constellation point.
module qam_lut
  import ofdm_map_pkg::*;
#(
  parameter int unsigned OUT_W      = 16,
  parameter int          UNIT_QPSK  = 5793,
  parameter int          UNIT_QAM16 = 2590
) (
  input  logic                    mode,
  input  logic [3:0]              bits,
  output logic signed [OUT_W-1:0] lut_i,
  output logic signed [OUT_W-1:0] lut_q
);

  localparam logic signed [OUT_W-1:0] QpskP = OUT_W'(UNIT_QPSK);
  localparam logic signed [OUT_W-1:0] QpskM = OUT_W'(-UNIT_QPSK);
  localparam logic signed [OUT_W-1:0] Qam1P = OUT_W'(UNIT_QAM16);
  localparam logic signed [OUT_W-1:0] Qam1M = OUT_W'(-UNIT_QAM16);
  // Outer level is formed at integer width, then narrowed.
  localparam logic signed [OUT_W-1:0] Qam3P = OUT_W'(3 * UNIT_QAM16);
  localparam logic signed [OUT_W-1:0] Qam3M = OUT_W'(-3 * UNIT_QAM16);

  function automatic logic signed [OUT_W-1:0] lvl_val(input gray_lvl_e lvl);
    logic signed [OUT_W-1:0] v;
    unique case (lvl)
      LVL_M3:  v = Qam3M;
      LVL_M1:  v = Qam1M;
      LVL_P1:  v = Qam1P;
      default: v = Qam3P;
    endcase
    return v;
  endfunction

  always_comb begin
    if (mode == MOD_QAM16) begin
      lut_i = lvl_val(gray_to_lvl(bits[0], bits[1]));
      lut_q = lvl_val(gray_to_lvl(bits[2], bits[3]));
    end else begin
      lut_i = bits[0] ? QpskP : QpskM;
      lut_q = bits[1] ? QpskP : QpskM;
    end
  end

endmodule

// File: rtl/qam_mapper.sv
// Packs a serial bit stream into QPSK/16-QAM symbols with per-frame mode latch and
// start/end-of-frame flags.
module qam_mapper
  import ofdm_map_pkg::*;
#(
  parameter int unsigned OUT_W         = 16,
  parameter int unsigned SYM_PER_FRAME = 48,
  parameter int          UNIT_QPSK     = 5793,
  parameter int          UNIT_QAM16    = 2590
) (
  input  logic                    qam_clk,
  input  logic                    qam_rst_n,
  input  logic                    din,
  input  logic                    din_valid,
  input  logic                    mod_sel,
  input  logic                    flush,
  output logic signed [OUT_W-1:0] sym_i,
  output logic signed [OUT_W-1:0] sym_q,
  output logic                    sym_valid,
  output logic                    sym_sof,
  output logic                    sym_eof,
  output logic                    frame_mode
);

  localparam int unsigned CntW = (SYM_PER_FRAME > 1) ? $clog2(SYM_PER_FRAME) : 1;
  localparam logic [CntW-1:0] LastSym = CntW'(SYM_PER_FRAME - 1);

  logic [1:0]              bit_cnt_q, bit_cnt_d;
  logic [3:0]              bits_q, bits_d;
  logic [CntW-1:0]         sym_cnt_q, sym_cnt_d;
  logic                    frame_mode_q, frame_mode_d;
  logic signed [OUT_W-1:0] sym_i_q, sym_i_d, sym_q_q, sym_q_d;
  logic                    sym_valid_q, sym_valid_d;
  logic                    sym_sof_q, sym_sof_d, sym_eof_q, sym_eof_d;

  logic                    accept;
  logic                    first_bit;
  logic                    mode_cur;
  logic                    last_bit;
  logic signed [OUT_W-1:0] lut_i, lut_q;

  assign accept    = din_valid & ~flush;
  assign first_bit = (sym_cnt_q == '0) && (bit_cnt_q == '0);
  // The first bit of a frame uses the live mod_sel so it decides its own symbol size.
  assign mode_cur  = first_bit ? mod_sel : frame_mode_q;
  assign last_bit  = (bit_cnt_q == ((mode_cur == MOD_QAM16) ? 2'(BITS_QAM16 - 1)
                                                             : 2'(BITS_QPSK - 1)));

  always_comb begin
    bits_d = bits_q;
    if (accept) begin
      bits_d[bit_cnt_q] = din;
    end
  end

  qam_lut #(
    .OUT_W     (OUT_W),
    .UNIT_QPSK (UNIT_QPSK),
    .UNIT_QAM16(UNIT_QAM16)
  ) u_lut (
    .mode (mode_cur),
    .bits (bits_d),
    .lut_i(lut_i),
    .lut_q(lut_q)
  );

  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    sym_cnt_d    = sym_cnt_q;
    frame_mode_d = frame_mode_q;
    sym_i_d      = sym_i_q;
    sym_q_d      = sym_q_q;
    sym_valid_d  = 1'b0;
    sym_sof_d    = 1'b0;
    sym_eof_d    = 1'b0;

    if (flush) begin
      bit_cnt_d = '0;
      sym_cnt_d = '0;
    end else if (din_valid) begin
      if (first_bit) begin
        frame_mode_d = mod_sel;
      end
      if (last_bit) begin
        bit_cnt_d   = '0;
        sym_valid_d = 1'b1;
        sym_i_d     = lut_i;
        sym_q_d     = lut_q;
        sym_sof_d   = (sym_cnt_q == '0);
        sym_eof_d   = (sym_cnt_q == LastSym);
        sym_cnt_d   = (sym_cnt_q == LastSym) ? '0 : sym_cnt_q + 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge qam_clk or negedge qam_rst_n) begin
    if (!qam_rst_n) begin
      bit_cnt_q    <= '0;
      bits_q       <= '0;
      sym_cnt_q    <= '0;
      frame_mode_q <= 1'b0;
      sym_i_q      <= '0;
      sym_q_q      <= '0;
      sym_valid_q  <= 1'b0;
      sym_sof_q    <= 1'b0;
      sym_eof_q    <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      bits_q       <= bits_d;
      sym_cnt_q    <= sym_cnt_d;
      frame_mode_q <= frame_mode_d;
      sym_i_q      <= sym_i_d;
      sym_q_q      <= sym_q_d;
      sym_valid_q  <= sym_valid_d;
      sym_sof_q    <= sym_sof_d;
      sym_eof_q    <= sym_eof_d;
    end
  end

  assign sym_i      = sym_i_q;
  assign sym_q      = sym_q_q;
  assign sym_valid  = sym_valid_q;
  assign sym_sof    = sym_sof_q;
  assign sym_eof    = sym_eof_q;
  assign frame_mode = frame_mode_q;

endmodule

// File: tb/tb_qam_mapper.sv
// Self-checking bench for qam_mapper: directed scenarios plus random traffic against a
// queue-based reference model.
module tb_qam_mapper;

  localparam int SPF = 48;
  localparam int UQ  = 5793;
  localparam int U16 = 2590;

  logic               qam_clk;
  logic               qam_rst_n;
  logic               din;
  logic               din_valid;
  logic               mod_sel;
  logic               flush;
  logic signed [15:0] sym_i;
  logic signed [15:0] sym_q;
  logic               sym_valid;
  logic               sym_sof;
  logic               sym_eof;
  logic               frame_mode;

  qam_mapper #(
    .OUT_W        (16),
    .SYM_PER_FRAME(SPF),
    .UNIT_QPSK    (UQ),
    .UNIT_QAM16   (U16)
  ) dut (
    .qam_clk   (qam_clk),
    .qam_rst_n (qam_rst_n),
    .din       (din),
    .din_valid (din_valid),
    .mod_sel   (mod_sel),
    .flush     (flush),
    .sym_i     (sym_i),
    .sym_q     (sym_q),
    .sym_valid (sym_valid),
    .sym_sof   (sym_sof),
    .sym_eof   (sym_eof),
    .frame_mode(frame_mode)
  );

  initial qam_clk = 1'b0;
  always #5 qam_clk = ~qam_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: bits of the symbol in progress and position within frame.
  bit m_bits[$];
  int m_sym_idx;
  bit m_mode;
  int e_valid, e_i, e_q, e_sof, e_eof;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int gray_level(input bit first, input bit second);
    case ({first, second})
      2'b00:   return -3;
      2'b01:   return -1;
      2'b11:   return 1;
      default: return 3;
    endcase
  endfunction

  task automatic model_reset();
    m_bits.delete();
    m_sym_idx = 0;
    m_mode    = 0;
    e_valid   = 0;
    e_i       = 0;
    e_q       = 0;
    e_sof     = 0;
    e_eof     = 0;
  endtask

  task automatic model_edge(input bit b, input bit vld, input bit sel, input bit fl);
    int n;
    e_valid = 0;
    e_sof   = 0;
    e_eof   = 0;
    if (fl) begin
      m_bits.delete();
      m_sym_idx = 0;
    end else if (vld) begin
      if (m_bits.size() == 0 && m_sym_idx == 0) m_mode = sel;
      m_bits.push_back(b);
      n = m_mode ? 4 : 2;
      if (m_bits.size() == n) begin
        if (m_mode) begin
          e_i = gray_level(m_bits[0], m_bits[1]) * U16;
          e_q = gray_level(m_bits[2], m_bits[3]) * U16;
        end else begin
          e_i = m_bits[0] ? UQ : -UQ;
          e_q = m_bits[1] ? UQ : -UQ;
        end
        e_valid   = 1;
        e_sof     = (m_sym_idx == 0);
        e_eof     = (m_sym_idx == SPF - 1);
        m_sym_idx = (m_sym_idx + 1) % SPF;
        m_bits.delete();
      end
    end
  endtask

  task automatic check_all();
    check("sym_valid", int'(sym_valid), e_valid);
    check("sym_i", int'(sym_i), e_i);
    check("sym_q", int'(sym_q), e_q);
    check("sym_sof", int'(sym_sof), e_sof);
    check("sym_eof", int'(sym_eof), e_eof);
    check("frame_mode", int'(frame_mode), int'(m_mode));
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare just after it.
  task automatic step(input bit b, input bit vld, input bit sel, input bit fl);
    din       = b;
    din_valid = vld;
    mod_sel   = sel;
    flush     = fl;
    @(posedge qam_clk);
    model_edge(b, vld, sel, fl);
    #1;
    check_all();
  endtask

  int sof_cnt, eof_cnt;
  bit gap_bits[8];
  bit sel_r;

  initial begin
    din       = 1'b0;
    din_valid = 1'b0;
    mod_sel   = 1'b0;
    flush     = 1'b0;
    qam_rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge qam_clk);
    #1;
    check_all();
    qam_rst_n = 1'b1;

    // 16-QAM 1,0,1,1 -> +3U / +U, first of frame
    step(1, 1, 1, 0);
    step(0, 1, 1, 0);
    step(1, 1, 1, 0);
    check("qam_early_valid", int'(sym_valid), 0);
    step(1, 1, 1, 0);
    check("qam_i_const", int'(sym_i), 7770);
    check("qam_q_const", int'(sym_q), 2590);
    check("qam_sof_const", int'(sym_sof), 1);
    step(0, 0, 1, 0);

    // QPSK in a fresh frame
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    check("qpsk_i_const", int'(sym_i), -5793);
    check("qpsk_q_const", int'(sym_q), 5793);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    check("qpsk2_i_const", int'(sym_i), 5793);
    step(0, 0, 0, 0);

    // Gapped 16-QAM run
    step(0, 0, 1, 1);
    gap_bits = '{0, 0, 0, 0, 1, 0, 1, 0};
    foreach (gap_bits[k]) begin
      step(gap_bits[k], 1, 1, 0);
      if (k == 3) check("gap_i0_const", int'(sym_i), -7770);
      step(0, 0, 1, 0);
      if (k == 7) check("gap_i1_const", int'(sym_i), 7770);
    end

    // Full frame of 16-QAM, mod_sel dropped mid-frame, then first symbol of next frame
    step(0, 0, 1, 1);
    sof_cnt = 0;
    eof_cnt = 0;
    for (int k = 0; k < 196; k++) begin
      sel_r = (k < 80);
      step(1'($urandom_range(1)), 1, sel_r, 0);
      if (sym_valid) begin
        sof_cnt += int'(sym_sof);
        eof_cnt += int'(sym_eof);
      end
      if (k == 191) check("frame_mode_held", int'(frame_mode), 1);
    end
    step(0, 0, 0, 0);
    check("frame_sof_count", sof_cnt, 2);
    check("frame_eof_count", eof_cnt, 1);
    check("frame_mode_new", int'(frame_mode), 0);

    // Flush after 3 bits, with a valid bit on the flush edge
    step(0, 0, 1, 1);
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    step(0, 1, 1, 1);
    for (int k = 0; k < 4; k++) step(1, 1, 1, 0);
    check("flush_i_const", int'(sym_i), 2590);
    check("flush_sof_const", int'(sym_sof), 1);

    // Asynchronous reset mid-symbol
    step(1, 1, 1, 0);
    step(1, 1, 1, 0);
    #2;
    qam_rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge qam_clk);
    #1;
    qam_rst_n = 1'b1;
    step(1, 1, 1, 0);
    step(1, 1, 1, 0);
    step(0, 1, 1, 0);
    step(1, 1, 1, 0);
    check("post_rst_sof", int'(sym_sof), 1);
    check("post_rst_i", int'(sym_i), 2590);

    // Random traffic
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(99) < 3) sel_r = ~sel_r;
      step(1'($urandom_range(1)), ($urandom_range(99) < 70), sel_r,
           ($urandom_range(199) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
